// File: rtl/udp_128bit_recv_if.sv
// Bus bundle for udp_128bit_recv: the UDP payload stream from the RX parser
// and the 128-bit word handshake towards the DDR3 writer.
// The slave modport is the receiver's view. The master modport is the
// surrounding system's view (parser plus DDR3 writer).
interface udp_128bit_recv_if;
    logic         udp_rx_start;
    logic [15:0]  udp_rx_len;
    logic         udp_rx_de;
    logic [7:0]   udp_rx_data;
    logic         udp_rx_end;
    logic [127:0] ddr3_wrdata;
    logic         ddr3_wr_valid;
    logic         ddr3_wr_last;
    logic         ddr3_wr_ack;

    modport master (
        output udp_rx_start,
        output udp_rx_len,
        output udp_rx_de,
        output udp_rx_data,
        output udp_rx_end,
        output ddr3_wr_ack,
        input  ddr3_wrdata,
        input  ddr3_wr_valid,
        input  ddr3_wr_last
    );

    modport slave (
        input  udp_rx_start,
        input  udp_rx_len,
        input  udp_rx_de,
        input  udp_rx_data,
        input  udp_rx_end,
        input  ddr3_wr_ack,
        output ddr3_wrdata,
        output ddr3_wr_valid,
        output ddr3_wr_last
    );
endinterface

// File: rtl/udp_128bit_recv.sv
// UDP payload receiver for the MJPEG capture chain.
// It strips the 2-byte sign header (last-frame flag and frame rank) and packs
// the JPEG bytes MSB-first into 128-bit words. Each word goes to the DDR3
// writer through a valid/ack handshake. A short final word is left-aligned
// and zero-padded. Truncated or badly sized packets end with an error pulse
// instead of a done pulse.
module udp_128bit_recv #(
    parameter logic [15:0] MAX_UDP_LEN = 16'd1472
) (
    input  logic                    i_udp_clk50m,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    udp_128bit_recv_if.slave        bus,
    output logic                    o_frame_last_flag,
    output logic [14:0]             o_mjpeg_frame_rank,
    output logic [15:0]             o_jpeg_len,
    output logic                    o_pkt_done,
    output logic                    o_pkt_err,
    output logic                    o_overflow,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SIGN_BYTE_1,
        SIGN_BYTE_2,
        PAYLOAD,
        FLUSH,
        DRAIN,
        SKIP
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           w_set_trunc;

    logic           r_trunc;
    logic [15:0]    r_jpeg_len;
    logic [3:0]     r_byte_cnt;
    logic [15:0]    r_data_cnt;
    logic [127:0]   r_pack;
    logic           r_last_flag;
    logic [14:0]    r_rank;
    logic           r_pkt_done;
    logic           r_pkt_err;
    logic           r_busy;

    logic [127:0]   r_wrdata;
    logic           r_wr_valid;
    logic           r_wr_last;
    logic           r_overflow;

    logic           w_accept;
    logic           w_len_bad;
    logic           w_pay_byte;
    logic           w_last_byte;
    logic [3:0]     w_cnt_after;
    logic [127:0]   w_pack_next;
    logic [4:0]     w_pad_bytes;
    logic [7:0]     w_pad_shift;
    logic [127:0]   w_flush_word;
    logic           w_word_load;
    logic [127:0]   w_load_data;
    logic           w_load_last;
    logic           w_ack;

    assign w_accept     = i_en && bus.udp_rx_start;
    assign w_len_bad    = (bus.udp_rx_len < 16'd2) || (bus.udp_rx_len > MAX_UDP_LEN);
    assign w_pay_byte   = (r_state == PAYLOAD) && bus.udp_rx_de;
    assign w_last_byte  = w_pay_byte && (r_data_cnt == (r_jpeg_len - 16'd1));
    assign w_cnt_after  = r_byte_cnt + {3'b000, bus.udp_rx_de};
    assign w_pack_next  = {r_pack[119:0], bus.udp_rx_data};
    assign w_pad_bytes  = 5'd16 - {1'b0, r_byte_cnt};
    assign w_pad_shift  = {w_pad_bytes, 3'b000};
    assign w_flush_word = r_pack << w_pad_shift;

    // A word leaves the packer on the 16th byte, or as a padded word from FLUSH.
    assign w_word_load  = (w_pay_byte && (r_byte_cnt == 4'd15)) || (r_state == FLUSH);
    assign w_load_data  = (r_state == FLUSH) ? w_flush_word : w_pack_next;
    assign w_load_last  = (r_state == FLUSH) || w_last_byte || bus.udp_rx_end;
    assign w_ack        = r_wr_valid && bus.ddr3_wr_ack;

    // State register.
    always_ff @(posedge i_udp_clk50m) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a same-cycle byte is consumed before an end pulse.
    always_comb begin
        w_next_state = r_state;
        w_set_trunc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_len_bad ? SKIP : SIGN_BYTE_1;
                end
            end
            SIGN_BYTE_1: begin
                if (bus.udp_rx_end) begin
                    w_next_state = DRAIN;
                    w_set_trunc  = 1'b1;
                end else if (bus.udp_rx_de) begin
                    w_next_state = SIGN_BYTE_2;
                end
            end
            SIGN_BYTE_2: begin
                if (bus.udp_rx_de && (r_jpeg_len == 16'd0)) begin
                    w_next_state = DRAIN;
                end else if (bus.udp_rx_end) begin
                    w_next_state = DRAIN;
                    w_set_trunc  = 1'b1;
                end else if (bus.udp_rx_de) begin
                    w_next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_last_byte || bus.udp_rx_end) begin
                    w_next_state = (w_cnt_after != 4'd0) ? FLUSH : DRAIN;
                    w_set_trunc  = !w_last_byte;
                end
            end
            FLUSH: begin
                w_next_state = DRAIN;
            end
            DRAIN: begin
                if (!r_wr_valid) begin
                    w_next_state = IDLE;
                end
            end
            SKIP: begin
                if (bus.udp_rx_end) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Packet bookkeeping: header fields, counters, packing and status pulses.
    always_ff @(posedge i_udp_clk50m) begin
        if (!i_rst_n) begin
            r_trunc     <= 1'b0;
            r_jpeg_len  <= 16'd0;
            r_byte_cnt  <= 4'd0;
            r_data_cnt  <= 16'd0;
            r_pack      <= 128'd0;
            r_last_flag <= 1'b0;
            r_rank      <= 15'd0;
            r_pkt_done  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            r_pkt_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_trunc    <= 1'b0;
                        r_byte_cnt <= 4'd0;
                        r_data_cnt <= 16'd0;
                        if (!w_len_bad) begin
                            r_jpeg_len <= bus.udp_rx_len - 16'd2;
                        end
                    end
                end
                SIGN_BYTE_1: begin
                    if (bus.udp_rx_de) begin
                        r_last_flag  <= bus.udp_rx_data[7];
                        r_rank[14:8] <= bus.udp_rx_data[6:0];
                    end
                end
                SIGN_BYTE_2: begin
                    if (bus.udp_rx_de) begin
                        r_rank[7:0] <= bus.udp_rx_data;
                        r_byte_cnt  <= 4'd0;
                        r_data_cnt  <= 16'd0;
                    end
                end
                PAYLOAD: begin
                    if (bus.udp_rx_de) begin
                        r_pack     <= w_pack_next;
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        r_data_cnt <= r_data_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (!r_wr_valid) begin
                        r_busy     <= 1'b0;
                        r_pkt_done <= !r_trunc;
                        r_pkt_err  <= r_trunc;
                    end
                end
                SKIP: begin
                    if (bus.udp_rx_end) begin
                        r_busy    <= 1'b0;
                        r_pkt_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (w_set_trunc) begin
                r_trunc <= 1'b1;
            end
        end
    end

    // Output word holding register; a new word overwrites an unacked one and flags overflow.
    always_ff @(posedge i_udp_clk50m) begin
        if (!i_rst_n) begin
            r_wrdata   <= 128'd0;
            r_wr_valid <= 1'b0;
            r_wr_last  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_word_load) begin
                r_wrdata   <= w_load_data;
                r_wr_valid <= 1'b1;
                r_wr_last  <= w_load_last;
                if (r_wr_valid && !bus.ddr3_wr_ack) begin
                    r_overflow <= 1'b1;
                end
            end else if (w_ack) begin
                r_wr_valid <= 1'b0;
                r_wr_last  <= 1'b0;
            end
        end
    end

    assign bus.ddr3_wrdata   = r_wrdata;
    assign bus.ddr3_wr_valid = r_wr_valid;
    assign bus.ddr3_wr_last  = r_wr_last;

    assign o_frame_last_flag  = r_last_flag;
    assign o_mjpeg_frame_rank = r_rank;
    assign o_jpeg_len         = r_jpeg_len;
    assign o_pkt_done         = r_pkt_done;
    assign o_pkt_err          = r_pkt_err;
    assign o_overflow         = r_overflow;
    assign o_busy             = r_busy;

endmodule

// File: tb/tb_udp_128bit_recv.sv
// Directed testbench for udp_128bit_recv: nominal, partial, header-only,
// bad-length, truncated, coincident-ack, backpressure and mid-packet reset.
module tb_udp_128bit_recv;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         frameLastFlag;
    logic [14:0]  frameRank;
    logic [15:0]  jpegLen;
    logic         pktDone;
    logic         pktErr;
    logic         overflow;
    logic         busy;

    int           assertCnt;
    int           failCnt;
    int           doneCnt;
    int           errCnt;
    int           validCnt;
    int           ackDelay;
    bit           ackHold;
    logic [128:0] capQ[$];

    udp_128bit_recv_if u_if();

    udp_128bit_recv #(.MAX_UDP_LEN(16'd1472)) dut (
        .i_udp_clk50m       (clk),
        .i_rst_n            (rst_n),
        .i_en               (en),
        .bus                (u_if),
        .o_frame_last_flag  (frameLastFlag),
        .o_mjpeg_frame_rank (frameRank),
        .o_jpeg_len         (jpegLen),
        .o_pkt_done         (pktDone),
        .o_pkt_err          (pktErr),
        .o_overflow         (overflow),
        .o_busy             (busy)
    );

    // 50 MHz clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // DDR3 writer model: acks a pending word ackDelay cycles after it appears.
    initial begin
        int  waitCnt;
        bit  ackPulsed;
        waitCnt   = 0;
        ackPulsed = 1'b0;
        u_if.ddr3_wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ackPulsed) begin
                u_if.ddr3_wr_ack = 1'b0;
                waitCnt   = 0;
                ackPulsed = 1'b0;
            end else if (u_if.ddr3_wr_valid) begin
                if ((waitCnt >= ackDelay) && !ackHold) begin
                    u_if.ddr3_wr_ack = 1'b1;
                    ackPulsed = 1'b1;
                end else begin
                    u_if.ddr3_wr_ack = 1'b0;
                end
                waitCnt++;
            end else begin
                u_if.ddr3_wr_ack = 1'b0;
                waitCnt = 0;
            end
        end
    end

    // Monitor on the falling edge: capture handshaken words and count pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.ddr3_wr_valid && u_if.ddr3_wr_ack) begin
                capQ.push_back({u_if.ddr3_wr_last, u_if.ddr3_wrdata});
            end
            if (pktDone) doneCnt++;
            if (pktErr) errCnt++;
            if (u_if.ddr3_wr_valid) validCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        assertCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearStats();
        doneCnt  = 0;
        errCnt   = 0;
        validCnt = 0;
        capQ.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends start, the two sign bytes, nPay payload bytes counting up from firstByte, then optionally end.
    task automatic applyStimulus(input logic [15:0] len, input logic [15:0] hdr, input int nPay,
                                 input logic [7:0] firstByte, input bit sendEnd);
        tick();
        u_if.udp_rx_start = 1'b1;
        u_if.udp_rx_len   = len;
        tick();
        u_if.udp_rx_start = 1'b0;
        u_if.udp_rx_de    = 1'b1;
        u_if.udp_rx_data  = hdr[15:8];
        tick();
        u_if.udp_rx_data  = hdr[7:0];
        for (int i = 0; i < nPay; i++) begin
            tick();
            u_if.udp_rx_data = firstByte + 8'(i);
        end
        tick();
        u_if.udp_rx_de   = 1'b0;
        u_if.udp_rx_data = 8'h00;
        if (sendEnd) begin
            u_if.udp_rx_end = 1'b1;
            tick();
            u_if.udp_rx_end = 1'b0;
        end
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (busy && (n < limit)) begin
            tick();
            n++;
        end
        checkOutput("idle reached", {127'd0, busy}, 128'd0);
        tick();
        tick();
    endtask

    task automatic checkWord(input string tag, input int idx, input logic [127:0] expData, input logic expLast);
        logic [128:0] w;
        w = '1;
        if (idx < capQ.size()) w = capQ[idx];
        checkOutput({tag, " data"}, w[127:0], expData);
        checkOutput({tag, " last"}, {127'd0, w[128]}, {127'd0, expLast});
    endtask

    task automatic checkCounts(input string tag, input int nWords, input int nDone, input int nErr);
        checkOutput({tag, " words"}, 128'(capQ.size()), 128'(nWords));
        checkOutput({tag, " done"}, 128'(doneCnt), 128'(nDone));
        checkOutput({tag, " err"}, 128'(errCnt), 128'(nErr));
    endtask

    initial begin
        assertCnt = 0;
        failCnt   = 0;
        ackDelay  = 2;
        ackHold   = 1'b0;
        clearStats();
        rst_n = 1'b0;
        en    = 1'b1;
        u_if.udp_rx_start = 1'b0;
        u_if.udp_rx_len   = 16'd0;
        u_if.udp_rx_de    = 1'b0;
        u_if.udp_rx_data  = 8'h00;
        u_if.udp_rx_end   = 1'b0;
        repeat (3) tick();
        checkOutput("reset status", {90'd0, busy, u_if.ddr3_wr_valid, u_if.ddr3_wr_last, frameLastFlag,
                    frameRank, jpegLen, overflow, pktDone, pktErr}, 128'd0);
        checkOutput("reset wrdata", u_if.ddr3_wrdata, 128'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] nominal packet");
        clearStats();
        applyStimulus(16'd34, 16'h8005, 32, 8'h00, 1'b1);
        waitIdle(200);
        checkOutput("nominal rank", {113'd0, frameRank}, 128'd5);
        checkOutput("nominal flag", {127'd0, frameLastFlag}, 128'd1);
        checkOutput("nominal jpeg_len", {112'd0, jpegLen}, 128'd32);
        checkCounts("nominal", 2, 1, 0);
        checkWord("nominal w0", 0, 128'h000102030405060708090A0B0C0D0E0F, 1'b0);
        checkWord("nominal w1", 1, 128'h101112131415161718191A1B1C1D1E1F, 1'b1);
        checkOutput("nominal overflow", {127'd0, overflow}, 128'd0);

        $display("[TB] partial last word");
        clearStats();
        applyStimulus(16'd22, 16'h0123, 20, 8'h00, 1'b1);
        waitIdle(200);
        checkOutput("partial rank", {113'd0, frameRank}, 128'h123);
        checkOutput("partial flag", {127'd0, frameLastFlag}, 128'd0);
        checkOutput("partial jpeg_len", {112'd0, jpegLen}, 128'd20);
        checkCounts("partial", 2, 1, 0);
        checkWord("partial w0", 0, 128'h000102030405060708090A0B0C0D0E0F, 1'b0);
        checkWord("partial w1", 1, {32'h10111213, 96'd0}, 1'b1);

        $display("[TB] header only and bad lengths");
        clearStats();
        applyStimulus(16'd2, 16'h0001, 0, 8'h00, 1'b1);
        waitIdle(100);
        checkCounts("hdronly", 0, 1, 0);
        checkOutput("hdronly valid", 128'(validCnt), 128'd0);
        checkOutput("hdronly jpeg_len", {112'd0, jpegLen}, 128'd0);
        checkOutput("hdronly rank", {113'd0, frameRank}, 128'd1);
        clearStats();
        applyStimulus(16'd1, 16'h0004, 0, 8'h00, 1'b1);
        waitIdle(100);
        checkCounts("len1", 0, 0, 1);
        checkOutput("len1 valid", 128'(validCnt), 128'd0);
        clearStats();
        applyStimulus(16'd1500, 16'h0005, 6, 8'h00, 1'b1);
        waitIdle(100);
        checkCounts("len1500", 0, 0, 1);
        checkOutput("len1500 valid", 128'(validCnt), 128'd0);
        checkOutput("badlen jpeg_len kept", {112'd0, jpegLen}, 128'd0);

        $display("[TB] truncated packet");
        clearStats();
        applyStimulus(16'd100, 16'h0007, 10, 8'hA0, 1'b1);
        waitIdle(200);
        checkOutput("trunc jpeg_len", {112'd0, jpegLen}, 128'd98);
        checkCounts("trunc", 1, 0, 1);
        checkWord("trunc w0", 0, {80'hA0A1A2A3A4A5A6A7A8A9, 48'd0}, 1'b1);

        $display("[TB] ack coincident with completion");
        clearStats();
        ackDelay = 15;
        applyStimulus(16'd34, 16'h0002, 32, 8'h20, 1'b1);
        waitIdle(200);
        checkCounts("coinc", 2, 1, 0);
        checkWord("coinc w0", 0, 128'h202122232425262728292A2B2C2D2E2F, 1'b0);
        checkWord("coinc w1", 1, 128'h303132333435363738393A3B3C3D3E3F, 1'b1);
        checkOutput("coinc overflow", {127'd0, overflow}, 128'd0);

        $display("[TB] backpressure");
        clearStats();
        ackDelay = 2;
        ackHold  = 1'b1;
        applyStimulus(16'd34, 16'h0003, 32, 8'h40, 1'b1);
        repeat (3) tick();
        checkOutput("bp valid held", {127'd0, u_if.ddr3_wr_valid}, 128'd1);
        checkOutput("bp overflow", {127'd0, overflow}, 128'd1);
        checkOutput("bp wrdata", u_if.ddr3_wrdata, 128'h505152535455565758595A5B5C5D5E5F);
        ackHold = 1'b0;
        waitIdle(200);
        checkCounts("bp", 1, 1, 0);
        checkWord("bp w0", 0, 128'h505152535455565758595A5B5C5D5E5F, 1'b1);
        clearStats();
        applyStimulus(16'd2, 16'h0009, 0, 8'h00, 1'b1);
        waitIdle(100);
        checkOutput("bp overflow sticky", {127'd0, overflow}, 128'd1);

        $display("[TB] reset mid payload");
        applyStimulus(16'd50, 16'h8123, 10, 8'h70, 1'b0);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst status", {90'd0, busy, u_if.ddr3_wr_valid, u_if.ddr3_wr_last, frameLastFlag,
                    frameRank, jpegLen, overflow, pktDone, pktErr}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        clearStats();
        applyStimulus(16'd22, 16'h0042, 20, 8'h60, 1'b1);
        waitIdle(200);
        checkCounts("postrst", 2, 1, 0);
        checkWord("postrst w0", 0, 128'h606162636465666768696A6B6C6D6E6F, 1'b0);
        checkWord("postrst w1", 1, {32'h70717273, 96'd0}, 1'b1);
        checkOutput("postrst rank", {113'd0, frameRank}, 128'h42);
        checkOutput("postrst overflow", {127'd0, overflow}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
